// File: rtl/gsram_rd_pkg.sv
// Shared types for the global SRAM read sequencer: operating modes, FSM states
// and the packed configuration record captured by cfg_vld.
package gsram_rd_pkg;

    localparam int GSRAM_ADDR_W     = 5;
    localparam int GSRAM_LEN_W      = GSRAM_ADDR_W + 1;
    localparam int GSRAM_REP_W      = 4;
    localparam int GSRAM_VEC_ADDR_W = 13;

    typedef enum logic [1:0] {
        RD_NULL  = 2'd0,
        RD_BURST = 2'd1,
        RD_PASS  = 2'd2,
        RD_RSVD  = 2'd3
    } rd_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        PASS  = 2'd2,
        DONE  = 2'd3
    } rd_state_e;

    // rpt is the number of extra passes; a burst plays rpt+1 times.
    typedef struct packed {
        rd_mode_e                    mode;
        logic [GSRAM_ADDR_W-1:0]     base;
        logic [GSRAM_LEN_W-1:0]      len;
        logic [GSRAM_REP_W-1:0]      rpt;
    } rd_cfg_t;

    // State entered from IDLE when a start is accepted with this configuration.
    // A zero-length burst and the reserved mode both collapse to a bare finish.
    function automatic rd_state_e start_target(input rd_cfg_t cfg);
        rd_state_e tgt;
        case (cfg.mode)
            RD_BURST: tgt = (cfg.len != '0) ? BURST : DONE;
            RD_PASS:  tgt = PASS;
            default:  tgt = DONE;
        endcase
        return tgt;
    endfunction

endpackage

// File: rtl/gsram_rd_addr_gen.sv
// Beat/pass counters and address-wrap logic for BURST mode. Holds the active
// copy of base/len/repeat so a later cfg_vld cannot disturb a running burst.
module gsram_rd_addr_gen
    import gsram_rd_pkg::*;
#(
    parameter int ADDR_W = GSRAM_ADDR_W,
    parameter int LEN_W  = GSRAM_LEN_W,
    parameter int REP_W  = GSRAM_REP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] base,
    input  logic [LEN_W-1:0]  len,
    input  logic [REP_W-1:0]  rpt,
    input  logic [ADDR_W-1:0] cur_addr,
    output logic [ADDR_W-1:0] next_addr,
    output logic              last_beat,
    output logic              last_pass
);

    logic [ADDR_W-1:0] act_base;
    logic [LEN_W-1:0]  act_len;
    logic [REP_W-1:0]  act_rpt;
    logic [LEN_W-1:0]  beat;
    logic [REP_W-1:0]  pass_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            act_base <= '0;
            act_len  <= '0;
            act_rpt  <= '0;
            beat     <= '0;
            pass_cnt <= '0;
        end else if (load) begin
            act_base <= base;
            act_len  <= len;
            act_rpt  <= rpt;
            beat     <= '0;
            pass_cnt <= '0;
        end else if (advance) begin
            if (last_beat) begin
                beat <= '0;
                if (!last_pass) begin
                    pass_cnt <= pass_cnt + REP_W'(1);
                end
            end else begin
                beat <= beat + LEN_W'(1);
            end
        end
    end

    // Length is never zero while bursting, so len-1 cannot underflow here.
    assign last_beat = (beat == act_len - LEN_W'(1));
    assign last_pass = (pass_cnt == act_rpt);

    // The address naturally wraps modulo 2^ADDR_W; a new pass restarts at base.
    assign next_addr = last_beat ? act_base : cur_addr + ADDR_W'(1);

endmodule

// File: rtl/global_sram_rd_seq.sv
// Read-address sequencer for the global activation SRAM: repeated sequential
// bursts under backpressure, vector-unit pass-through, or a bare finish.
module global_sram_rd_seq
    import gsram_rd_pkg::*;
#(
    parameter int ADDR_W     = GSRAM_ADDR_W,
    parameter int LEN_W      = GSRAM_LEN_W,
    parameter int REP_W      = GSRAM_REP_W,
    parameter int VEC_ADDR_W = GSRAM_VEC_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_vld,
    input  logic [1:0]            cfg_mode,
    input  logic [ADDR_W-1:0]     cfg_base,
    input  logic [LEN_W-1:0]      cfg_len,
    input  logic [REP_W-1:0]      cfg_repeat,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  sram_ready,
    input  logic [VEC_ADDR_W-1:0] vec_addr,
    input  logic                  vec_vld,
    output logic                  sram_ren,
    output logic [ADDR_W-1:0]     sram_raddr,
    output logic                  busy,
    output logic                  finish
);

    rd_cfg_t           shadow;
    rd_state_e         state_q;
    rd_state_e         state_nxt;
    logic              ren_nxt;
    logic [ADDR_W-1:0] raddr_nxt;
    logic              load;
    logic              advance;
    logic              accept;
    logic [ADDR_W-1:0] next_addr;
    logic              last_beat;
    logic              last_pass;
    logic              vec_hi_unused;

    // Upper pass-through address bits address nothing in this SRAM.
    assign vec_hi_unused = ^vec_addr[VEC_ADDR_W-1:ADDR_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
        end else if (cfg_vld) begin
            shadow <= '{mode: rd_mode_e'(cfg_mode), base: cfg_base,
                        len: cfg_len, rpt: cfg_repeat};
        end
    end

    gsram_rd_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W),
        .REP_W  (REP_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .advance   (advance),
        .base      (shadow.base),
        .len       (shadow.len),
        .rpt       (shadow.rpt),
        .cur_addr  (sram_raddr),
        .next_addr (next_addr),
        .last_beat (last_beat),
        .last_pass (last_pass)
    );

    assign accept = sram_ren & sram_ready;

    always_comb begin
        state_nxt = state_q;
        ren_nxt   = 1'b0;
        raddr_nxt = sram_raddr;
        load      = 1'b0;
        advance   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = start_target(shadow);
                    if (state_nxt == BURST) begin
                        ren_nxt   = 1'b1;
                        raddr_nxt = shadow.base;
                    end
                end
            end
            BURST: begin
                // Abort wins over a beat accepted in the same cycle.
                if (stop) begin
                    state_nxt = IDLE;
                end else if (accept) begin
                    advance = 1'b1;
                    if (last_beat && last_pass) begin
                        state_nxt = DONE;
                    end else begin
                        ren_nxt   = 1'b1;
                        raddr_nxt = next_addr;
                    end
                end else begin
                    ren_nxt = 1'b1;
                end
            end
            PASS: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else begin
                    ren_nxt   = vec_vld;
                    raddr_nxt = vec_addr[ADDR_W-1:0];
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // finish and busy follow the next state so they line up with it exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sram_ren   <= 1'b0;
            sram_raddr <= '0;
            busy       <= 1'b0;
            finish     <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            sram_ren   <= ren_nxt;
            sram_raddr <= raddr_nxt;
            busy       <= (state_nxt != IDLE);
            finish     <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_global_sram_rd_seq.sv
// Directed bench for global_sram_rd_seq: bursts with wrap/repeat/stalls, NULL,
// zero-length, PASS, stop, reset and reconfiguration while busy.
module tb_global_sram_rd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_vld;
    logic [1:0]  cfg_mode;
    logic [4:0]  cfg_base;
    logic [5:0]  cfg_len;
    logic [3:0]  cfg_repeat;
    logic        start;
    logic        stop;
    logic        sram_ready;
    logic [12:0] vec_addr;
    logic        vec_vld;
    logic        sram_ren;
    logic [4:0]  sram_raddr;
    logic        busy;
    logic        finish;

    int testCount = 0;
    int failCount = 0;

    logic [4:0] expAddr [0:15];
    logic       readyPat [0:15];

    always #5 clk = ~clk;

    global_sram_rd_seq dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_vld    (cfg_vld),
        .cfg_mode   (cfg_mode),
        .cfg_base   (cfg_base),
        .cfg_len    (cfg_len),
        .cfg_repeat (cfg_repeat),
        .start      (start),
        .stop       (stop),
        .sram_ready (sram_ready),
        .vec_addr   (vec_addr),
        .vec_vld    (vec_vld),
        .sram_ren   (sram_ren),
        .sram_raddr (sram_raddr),
        .busy       (busy),
        .finish     (finish)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive start/stop for one cycle; returns at the next falling edge.
    task automatic applyStimulus(input logic st, input logic sp);
        start = st;
        stop  = sp;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic setCfg(input logic [1:0] mode, input logic [4:0] base,
                          input logic [5:0] len, input logic [3:0] rpt);
        cfg_mode   = mode;
        cfg_base   = base;
        cfg_len    = len;
        cfg_repeat = rpt;
        cfg_vld    = 1'b1;
        @(negedge clk);
        cfg_vld    = 1'b0;
    endtask

    // Walks n request cycles against expAddr/readyPat, then expects one finish.
    task automatic playBurst(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            sram_ready = readyPat[i];
            checkOutput($sformatf("%s ren[%0d]", tag, i), 32'(sram_ren), 32'd1);
            checkOutput($sformatf("%s addr[%0d]", tag, i), 32'(sram_raddr), 32'(expAddr[i]));
            applyStimulus(1'b0, 1'b0);
        end
        sram_ready = 1'b1;
        checkOutput({tag, " finish"}, 32'(finish), 32'd1);
        checkOutput({tag, " ren off"}, 32'(sram_ren), 32'd0);
        checkOutput({tag, " busy in done"}, 32'(busy), 32'd1);
        applyStimulus(1'b0, 1'b0);
        checkOutput({tag, " finish once"}, 32'(finish), 32'd0);
        checkOutput({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    // Expect a bare finish pulse one cycle after start, with no read request.
    task automatic checkBareFinish(input string tag);
        applyStimulus(1'b1, 1'b0);
        checkOutput({tag, " finish"}, 32'(finish), 32'd1);
        checkOutput({tag, " no ren"}, 32'(sram_ren), 32'd0);
        checkOutput({tag, " busy"}, 32'(busy), 32'd1);
        applyStimulus(1'b0, 1'b0);
        checkOutput({tag, " finish once"}, 32'(finish), 32'd0);
        checkOutput({tag, " idle"}, 32'(busy), 32'd0);
        checkOutput({tag, " still no ren"}, 32'(sram_ren), 32'd0);
    endtask

    initial begin
        rst = 1'b1; cfg_vld = 1'b0; cfg_mode = 2'd0; cfg_base = '0; cfg_len = '0;
        cfg_repeat = '0; start = 1'b0; stop = 1'b0; sram_ready = 1'b1;
        vec_addr = '0; vec_vld = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset ren", 32'(sram_ren), 32'd0);
        checkOutput("reset raddr", 32'(sram_raddr), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset finish", 32'(finish), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // base=0 len=4 repeat=0, always ready
        setCfg(2'd1, 5'd0, 6'd4, 4'd0);
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin expAddr[i] = 5'(i); readyPat[i] = 1'b1; end
        playBurst("b4", 4);

        // base=30 len=4 repeat=1: wraps past 31 and restarts at base without a bubble
        setCfg(2'd1, 5'd30, 6'd4, 4'd1);
        applyStimulus(1'b1, 1'b0);
        expAddr[0] = 5'd30; expAddr[1] = 5'd31; expAddr[2] = 5'd0; expAddr[3] = 5'd1;
        expAddr[4] = 5'd30; expAddr[5] = 5'd31; expAddr[6] = 5'd0; expAddr[7] = 5'd1;
        for (int i = 0; i < 8; i++) readyPat[i] = 1'b1;
        playBurst("wrap", 8);

        // base=0 len=4 with sram_ready low on cycles 2-3: addr 1 held three cycles
        setCfg(2'd1, 5'd0, 6'd4, 4'd0);
        applyStimulus(1'b1, 1'b0);
        expAddr[0] = 5'd0; expAddr[1] = 5'd1; expAddr[2] = 5'd1;
        expAddr[3] = 5'd1; expAddr[4] = 5'd2; expAddr[5] = 5'd3;
        readyPat[0] = 1'b1; readyPat[1] = 1'b0; readyPat[2] = 1'b0;
        readyPat[3] = 1'b1; readyPat[4] = 1'b1; readyPat[5] = 1'b1;
        playBurst("stall", 6);

        // len=1 repeat=2: every beat is the last of its pass
        setCfg(2'd1, 5'd7, 6'd1, 4'd2);
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin expAddr[i] = 5'd7; readyPat[i] = 1'b1; end
        playBurst("len1", 3);

        setCfg(2'd0, 5'd9, 6'd4, 4'd0);
        checkBareFinish("null");
        setCfg(2'd1, 5'd9, 6'd0, 4'd3);
        checkBareFinish("len0");
        setCfg(2'd3, 5'd9, 6'd4, 4'd0);
        checkBareFinish("rsvd");

        // PASS: one-cycle registered forwarding, upper address bits dropped
        setCfg(2'd2, 5'd0, 6'd0, 4'd0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("pass entry ren", 32'(sram_ren), 32'd0);
        checkOutput("pass busy", 32'(busy), 32'd1);
        vec_vld = 1'b1; vec_addr = 13'h1A3; sram_ready = 1'b0;
        applyStimulus(1'b0, 1'b0);
        checkOutput("pass ren", 32'(sram_ren), 32'd1);
        checkOutput("pass raddr", 32'(sram_raddr), 32'h03);
        vec_vld = 1'b0;
        applyStimulus(1'b0, 1'b0);
        checkOutput("pass vld low", 32'(sram_ren), 32'd0);
        vec_vld = 1'b1; vec_addr = 13'h1FFE;
        applyStimulus(1'b0, 1'b0);
        checkOutput("pass raddr2", 32'(sram_raddr), 32'h1E);
        applyStimulus(1'b0, 1'b1);
        checkOutput("pass stop ren", 32'(sram_ren), 32'd0);
        checkOutput("pass stop finish", 32'(finish), 32'd0);
        checkOutput("pass stop busy", 32'(busy), 32'd0);
        vec_vld = 1'b0; sram_ready = 1'b1;
        applyStimulus(1'b0, 1'b0);
        checkOutput("pass after stop finish", 32'(finish), 32'd0);

        // mid-burst stop collides with an accept; stop wins
        setCfg(2'd1, 5'd0, 6'd8, 4'd0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("stop pre addr", 32'(sram_raddr), 32'd2);
        applyStimulus(1'b0, 1'b1);
        checkOutput("stop ren", 32'(sram_ren), 32'd0);
        checkOutput("stop busy", 32'(busy), 32'd0);
        checkOutput("stop finish", 32'(finish), 32'd0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("stop finish later", 32'(finish), 32'd0);

        // mid-burst reset
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        rst = 1'b0;
        checkOutput("rst ren", 32'(sram_ren), 32'd0);
        checkOutput("rst raddr", 32'(sram_raddr), 32'd0);
        checkOutput("rst busy", 32'(busy), 32'd0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("rst finish", 32'(finish), 32'd0);
        checkOutput("rst stays idle", 32'(sram_ren), 32'd0);

        // start and cfg_vld while busy leave the running burst alone
        setCfg(2'd1, 5'd4, 6'd3, 4'd0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("busy cfg addr0", 32'(sram_raddr), 32'd4);
        cfg_mode = 2'd1; cfg_base = 5'd20; cfg_len = 6'd2; cfg_repeat = 4'd0; cfg_vld = 1'b1;
        applyStimulus(1'b1, 1'b0);
        cfg_vld = 1'b0;
        expAddr[0] = 5'd5; expAddr[1] = 5'd6;
        readyPat[0] = 1'b1; readyPat[1] = 1'b1;
        playBurst("old cfg", 2);
        applyStimulus(1'b1, 1'b0);
        expAddr[0] = 5'd20; expAddr[1] = 5'd21;
        playBurst("new cfg", 2);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
